// File: rtl/axis_video_packer.sv
// ---------------------------------------------------------------------------
// axis_video_packer
//
// Bridges the pixel generator / timing stage to the HDMI block-design
// AXI4-Stream video input. Visible 12-bit pixels are captured together with
// their frame/line position tags, expanded to 24-bit colour, buffered in a
// small first-word-fall-through FIFO, and presented as an AXI4-Stream master
// that honours backpressure. If the sink stalls long enough to overflow the
// FIFO, the block records the overflow and resynchronises at the next frame
// start so the sink never sees a torn frame.
//
// Ports:
//   pixel_clk   - pixel clock; all logic runs on its rising edge
//   aresetn     - asynchronous active-low reset, synchronous release
//   pixel_x     - current column from the timing stage
//   pixel_y     - current row from the timing stage
//   video_on    - high in the visible area; qualifies rgb_in
//   rgb_in      - pixel colour {R4,G4,B4}
//   tdata       - stream pixel {R8,B8,G8}; zero while tvalid is low
//   tvalid      - stream valid (FIFO non-empty)
//   tuser       - start of frame, high on pixel (0,0)
//   tlast       - end of line, high on pixel x = H_ACTIVE-1
//   tready      - stream ready from the sink
//   overflow    - sticky flag: a pixel was dropped while streaming
//   frame_done  - one-cycle pulse after the final pixel of a frame is accepted
//   fifo_level  - current FIFO occupancy
// ---------------------------------------------------------------------------
module axis_video_packer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          pixel_clk,
    input  logic                          aresetn,
    input  logic [9:0]                    pixel_x,
    input  logic [9:0]                    pixel_y,
    input  logic                          video_on,
    input  logic [11:0]                   rgb_in,
    output logic [23:0]                   tdata,
    output logic                          tvalid,
    output logic                          tuser,
    output logic                          tlast,
    input  logic                          tready,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // One buffered pixel. last_line rides along so frame_done can be
    // generated at the moment the sink actually takes the final pixel.
    typedef struct packed {
        logic        last_line;
        logic        sof;
        logic        eol;
        logic [23:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        STREAM,
        DROP
    } state_t;

    state_t            state;
    entry_t            cap_entry;
    logic              cap_valid;
    entry_t            new_entry;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    entry_t            head;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop_in_stream;

    // Colour expansion and tag generation for the pixel currently on the
    // inputs. Nibble replication maps 0xF to 0xFF exactly, so full-scale
    // colours stay full-scale after expansion.
    always_comb begin
        new_entry           = '0;
        new_entry.data      = {rgb_in[11:8], rgb_in[11:8],
                               rgb_in[3:0],  rgb_in[3:0],
                               rgb_in[7:4],  rgb_in[7:4]};
        new_entry.sof       = (pixel_x == 10'd0) && (pixel_y == 10'd0);
        new_entry.eol       = (pixel_x == X_LAST);
        new_entry.last_line = (pixel_y == Y_LAST);
    end

    // Capture stage: registers each visible pixel with its tags. The FIFO
    // write decision is made one cycle later from this register, which is
    // why a pixel reaches the stream one edge after it is captured.
    always_ff @(posedge pixel_clk or negedge aresetn) begin
        if (!aresetn) begin
            cap_valid <= 1'b0;
            cap_entry <= '0;
        end else begin
            cap_valid <= video_on;
            if (video_on) begin
                cap_entry <= new_entry;
            end
        end
    end

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign pop   = !empty && tready;

    // Write decision per state. In STREAM a full FIFO can still accept a
    // pixel when the sink pops in the same cycle. In DROP a frame start is
    // only taken once the FIFO has fully drained, so the tail of the broken
    // frame is never glued onto the start of the new one.
    always_comb begin
        push           = 1'b0;
        drop_in_stream = 1'b0;
        unique case (state)
            SYNC_WAIT: push = cap_valid && cap_entry.sof;
            STREAM: begin
                push           = cap_valid && (!full || pop);
                drop_in_stream = cap_valid && full && !pop;
            end
            DROP:      push = cap_valid && cap_entry.sof && empty;
            default: begin
                push           = 1'b0;
                drop_in_stream = 1'b0;
            end
        endcase
    end

    // Frame synchronisation FSM with the sticky overflow flag. Overflow is
    // only cleared by reset so software can detect that a frame was lost
    // even after the stream has recovered.
    always_ff @(posedge pixel_clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= SYNC_WAIT;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                SYNC_WAIT: begin
                    if (push) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (drop_in_stream) begin
                        state    <= DROP;
                        overflow <= 1'b1;
                    end
                end
                DROP: begin
                    if (push) begin
                        state <= STREAM;
                    end
                end
                default: state <= SYNC_WAIT;
            endcase
        end
    end

    // FIFO storage. Contents need no reset: the pointers and level define
    // which entries are live, and those are cleared asynchronously.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_entry;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the
    // depth is a power of two; push and pop together leave the level as is.
    always_ff @(posedge pixel_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // End-of-frame pulse, raised the cycle after the sink accepts the last
    // pixel of the last visible line.
    always_ff @(posedge pixel_clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && head.eol && head.last_line;
        end
    end

    // First-word-fall-through output: the head entry is shown directly and
    // only changes on a pop, so it holds while the sink stalls. The payload
    // is forced to zero whenever nothing is valid.
    assign head       = mem[rd_ptr];
    assign tvalid     = !empty;
    assign tdata      = tvalid ? head.data : 24'd0;
    assign tuser      = tvalid && head.sof;
    assign tlast      = tvalid && head.eol;
    assign fifo_level = level;

endmodule

// File: tb/tb_axis_video_packer.sv
// ---------------------------------------------------------------------------
// tb_axis_video_packer
//
// Self-checking bench for axis_video_packer using a reduced raster
// (20x6 visible inside 24x8 total) so whole frames run quickly. A queue-based
// reference model tracks the expected stream; a colour table checks the
// nibble expansion; hand-written sequences cover backpressure, overflow,
// resync and mid-line reset.
// ---------------------------------------------------------------------------
module tb_axis_video_packer;

    localparam int H_ACTIVE   = 20;
    localparam int V_ACTIVE   = 6;
    localparam int FIFO_DEPTH = 16;
    localparam int H_TOTAL    = 24;
    localparam int V_TOTAL    = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    localparam int M_SYNC   = 0;
    localparam int M_STREAM = 1;
    localparam int M_DROP   = 2;

    logic              pixel_clk = 1'b0;
    logic              aresetn   = 1'b0;
    logic [9:0]        pixel_x   = '0;
    logic [9:0]        pixel_y   = '0;
    logic              video_on  = 1'b0;
    logic [11:0]       rgb_in    = '0;
    logic              tready    = 1'b0;
    logic [23:0]       tdata;
    logic              tvalid;
    logic              tuser;
    logic              tlast;
    logic              overflow;
    logic              frame_done;
    logic [LVL_W-1:0]  fifo_level;

    axis_video_packer #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .pixel_clk  (pixel_clk),
        .aresetn    (aresetn),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .rgb_in     (rgb_in),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tuser      (tuser),
        .tlast      (tlast),
        .tready     (tready),
        .overflow   (overflow),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    // Free-running pixel clock, 10 ns period.
    always #5 pixel_clk = ~pixel_clk;

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [23:0] data;
        bit          sof;
        bit          eol;
        bit          last;
    } beat_t;

    typedef struct {
        logic [11:0] rgb;
        logic [23:0] exp;
    } color_vec_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     hc = 0;
    int     vc = 0;

    beat_t  mq[$];
    beat_t  mcap;
    bit     mcap_valid;
    int     mmode;
    bit     movf;
    bit     mfd;

    int     beat_count;
    int     tuser_count;
    int     tlast_count;
    int     fd_count;
    int     first_tlast_idx;
    bit     first_beat_seen;
    bit     first_beat_tuser;

    color_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected beat for a pixel, from plain arithmetic on the colour nibbles.
    function automatic beat_t make_beat(input logic [11:0] rgb, input logic [9:0] x, input logic [9:0] y);
        beat_t bt;
        int r, g, b;
        r = int'(rgb[11:8]);
        g = int'(rgb[7:4]);
        b = int'(rgb[3:0]);
        bt.data = 24'((r * 17) * 65536 + (b * 17) * 256 + g * 17);
        bt.sof  = (x == 0) && (y == 0);
        bt.eol  = (int'(x) == H_ACTIVE - 1);
        bt.last = (int'(y) == V_ACTIVE - 1);
        return bt;
    endfunction

    task automatic model_reset();
        mq.delete();
        mcap_valid = 1'b0;
        mcap       = make_beat(12'h000, 10'd1, 10'd1);
        mmode      = M_SYNC;
        movf       = 1'b0;
        mfd        = 1'b0;
    endtask

    // One clock edge of the reference model: the pixel captured on the
    // previous edge is admitted or discarded, the sink takes the head if it
    // was ready, and the pixel on the inputs now becomes the captured one.
    task automatic model_step();
        bit pop;
        bit push;
        bit fd;
        int lvl;
        lvl  = mq.size();
        pop  = (lvl != 0) && (tready === 1'b1);
        push = 1'b0;
        if (mcap_valid) begin
            if (mmode == M_SYNC) begin
                if (mcap.sof) begin
                    push  = 1'b1;
                    mmode = M_STREAM;
                end
            end else if (mmode == M_STREAM) begin
                if (lvl < FIFO_DEPTH || pop) begin
                    push = 1'b1;
                end else begin
                    movf  = 1'b1;
                    mmode = M_DROP;
                end
            end else begin
                if (mcap.sof && lvl == 0) begin
                    push  = 1'b1;
                    mmode = M_STREAM;
                end
            end
        end
        fd = pop && mq[0].eol && mq[0].last;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(mcap);
        mfd        = fd;
        mcap_valid = video_on;
        mcap       = make_beat(rgb_in, pixel_x, pixel_y);
    endtask

    task automatic checkOutput();
        bit    v;
        beat_t h;
        v = (mq.size() != 0);
        h.data = 24'd0;
        h.sof  = 1'b0;
        h.eol  = 1'b0;
        h.last = 1'b0;
        if (v) h = mq[0];
        check("tvalid",     32'(tvalid),     32'(v));
        check("tdata",      32'(tdata),      32'(h.data));
        check("tuser",      32'(tuser),      32'(h.sof));
        check("tlast",      32'(tlast),      32'(h.eol));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check("overflow",   32'(overflow),   32'(movf));
        check("frame_done", 32'(frame_done), 32'(mfd));
    endtask

    task automatic clear_counters();
        beat_count       = 0;
        tuser_count      = 0;
        tlast_count      = 0;
        fd_count         = 0;
        first_tlast_idx  = 0;
        first_beat_seen  = 1'b0;
        first_beat_tuser = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, step the model and compare.
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic on,
                                 input logic [11:0] rgb, input logic rdy);
        pixel_x  = x;
        pixel_y  = y;
        video_on = on;
        rgb_in   = rgb;
        tready   = rdy;
        if (tvalid && tready) begin
            beat_count++;
            if (tuser) tuser_count++;
            if (tlast) begin
                tlast_count++;
                if (first_tlast_idx == 0) first_tlast_idx = beat_count;
            end
            if (!first_beat_seen) begin
                first_beat_seen  = 1'b1;
                first_beat_tuser = tuser;
            end
        end
        @(posedge pixel_clk);
        model_step();
        #1;
        if (frame_done) fd_count++;
        checkOutput();
    endtask

    task automatic advance_timing();
        hc++;
        if (hc == H_TOTAL) begin
            hc = 0;
            vc++;
            if (vc == V_TOTAL) vc = 0;
        end
    endtask

    task automatic next_pixel(input logic rdy, input logic [11:0] rgb);
        logic on;
        on = (hc < H_ACTIVE) && (vc < V_ACTIVE);
        applyStimulus(10'(hc), 10'(vc), on, rgb, rdy);
        advance_timing();
    endtask

    // Runs until the next pixel to be presented is (0,0); at most one frame.
    task automatic goto_frame_start(input logic rdy);
        while (!(hc == 0 && vc == 0)) begin
            next_pixel(rdy, 12'($urandom));
        end
    endtask

    // Asserts reset between edges, checks the immediate effect, holds it for
    // n edges while the raster keeps running, then releases between edges.
    task automatic do_reset(input int n);
        aresetn = 1'b0;
        #1;
        model_reset();
        check("reset tvalid", 32'(tvalid), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        checkOutput();
        for (int i = 0; i < n; i++) begin
            pixel_x  = 10'(hc);
            pixel_y  = 10'(vc);
            video_on = (hc < H_ACTIVE) && (vc < V_ACTIVE);
            rgb_in   = 12'($urandom);
            advance_timing();
            @(posedge pixel_clk);
            #1;
        end
        aresetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{rgb: 12'hF0A, exp: 24'hFFAA00};
        vecs[1] = '{rgb: 12'h123, exp: 24'h113322};
        vecs[2] = '{rgb: 12'hABC, exp: 24'hAACCBB};
        vecs[3] = '{rgb: 12'h000, exp: 24'h000000};
        vecs[4] = '{rgb: 12'hFFF, exp: 24'hFFFFFF};
        vecs[5] = '{rgb: 12'h5A0, exp: 24'h5500AA};

        model_reset();
        clear_counters();

        // Reset and release mid-line: nothing may stream before (0,0).
        do_reset(3);
        clear_counters();
        goto_frame_start(1'b1);
        check("no beats before first sof", 32'(beat_count), 32'd0);

        // Colour expansion table; FIFO drains every cycle so the head after
        // each edge is the previous table entry.
        for (int i = 0; i < 6; i++) begin
            next_pixel(1'b1, vecs[i].rgb);
            if (i >= 1) check($sformatf("colour[%0d]", i - 1), 32'(tdata), 32'(vecs[i-1].exp));
            if (i == 1) check("first beat tuser", 32'(tuser), 32'd1);
        end
        next_pixel(1'b1, 12'h000);
        check("colour[5]", 32'(tdata), 32'(vecs[5].exp));

        // Full frame of a constant colour with the sink always ready.
        goto_frame_start(1'b1);
        clear_counters();
        repeat (H_TOTAL * V_TOTAL) next_pixel(1'b1, 12'hF0A);
        check("frame beats", 32'(beat_count), 32'(H_ACTIVE * V_ACTIVE));
        check("frame tuser count", 32'(tuser_count), 32'd1);
        check("frame tlast count", 32'(tlast_count), 32'(V_ACTIVE));
        check("frame_done pulses", 32'(fd_count), 32'd1);
        check("frame first tuser", 32'(first_beat_tuser), 32'd1);
        check("frame overflow", 32'(overflow), 32'd0);

        // One line with tready toggling every cycle, then free-running.
        clear_counters();
        for (int i = 0; i < H_TOTAL; i++) next_pixel(1'((i + 1) % 2), 12'($urandom));
        goto_frame_start(1'b1);
        check("toggle tlast beat index", 32'(first_tlast_idx), 32'(H_ACTIVE));
        check("toggle frame beats", 32'(beat_count), 32'(H_ACTIVE * V_ACTIVE));
        check("toggle overflow", 32'(overflow), 32'd0);

        // Fill the FIFO, then push and pop together while full.
        repeat (17) next_pixel(1'b0, 12'($urandom));
        check("full level", 32'(fifo_level), 32'(FIFO_DEPTH));
        next_pixel(1'b1, 12'($urandom));
        check("full push+pop level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("full push+pop overflow", 32'(overflow), 32'd0);
        goto_frame_start(1'b1);
        check("full frame overflow", 32'(overflow), 32'd0);

        // Overflow: 17th buffered pixel is dropped, FIFO drains, then resync.
        repeat (18) next_pixel(1'b0, 12'($urandom));
        check("ovf level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("ovf flag", 32'(overflow), 32'd1);
        clear_counters();
        goto_frame_start(1'b1);
        check("ovf drained beats", 32'(beat_count), 32'(FIFO_DEPTH));
        clear_counters();
        repeat (H_TOTAL) next_pixel(1'b1, 12'($urandom));
        check("resync beat seen", 32'(first_beat_seen), 32'd1);
        check("resync first tuser", 32'(first_beat_tuser), 32'd1);
        check("ovf sticky", 32'(overflow), 32'd1);

        // Reset mid-line with eight entries buffered.
        goto_frame_start(1'b1);
        repeat (9) next_pixel(1'b0, 12'($urandom));
        check("pre-reset level", 32'(fifo_level), 32'd8);
        do_reset(2);
        clear_counters();
        goto_frame_start(1'b1);
        check("post-reset no beats", 32'(beat_count), 32'd0);
        check("post-reset overflow", 32'(overflow), 32'd0);
        clear_counters();
        repeat (H_TOTAL) next_pixel(1'b1, 12'($urandom));
        check("post-reset first tuser", 32'(first_beat_tuser), 32'd1);

        // Randomised traffic against the reference model.
        goto_frame_start(1'b1);
        repeat (8 * H_TOTAL * V_TOTAL) next_pixel(1'($urandom_range(0, 9) < 7), 12'($urandom));
        repeat (2 * H_TOTAL * V_TOTAL) next_pixel(1'b1, 12'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
